// File: rtl/code_lock_param_if.sv
// Keypad lock bus: digit entry controls from the pad wrapper and the status decode
// returned to the LEDs.
interface code_lock_param_if #(
  parameter int CODE_LEN = 4,
  parameter int DIGIT_W  = 4
);
  localparam int IDX_W = $clog2(CODE_LEN + 1);

  logic               enter;
  logic [DIGIT_W-1:0] digit;
  logic               lock_cmd;
  logic               prog;
  logic               locked;
  logic               unlocked;
  logic               error_o;
  logic               lockout;
  logic [2:0]         state_code;
  logic [IDX_W-1:0]   digit_idx;

  modport master (
    output enter, digit, lock_cmd, prog,
    input  locked, unlocked, error_o, lockout, state_code, digit_idx
  );

  modport slave (
    input  enter, digit, lock_cmd, prog,
    output locked, unlocked, error_o, lockout, state_code, digit_idx
  );
endinterface

// File: rtl/code_lock_param.sv
// Parametrised keypad code lock with failure lockout and user reprogramming.
// Optional auto-relock from UNLOCKED is built when CODE_LOCK_AUTO_RELOCK_EN is defined.
module code_lock_param #(
  parameter int                           CODE_LEN       = 4,
  parameter int                           DIGIT_W        = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  CODE_INIT      = 16'h1234,
  parameter int                           MAX_TRIES      = 3,
  parameter int                           LOCKOUT_CYCLES = 1000,
  parameter int                           UNLOCK_CYCLES  = 500
) (
  input logic                clk,
  input logic                reset,
  code_lock_param_if.slave   bus
);
  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int IDX_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_UNLOCKED = 3'd1,
    S_ERROR    = 3'd2,
    S_LOCKOUT  = 3'd3,
    S_PROGRAM  = 3'd4
  } state_t;

  // Digit 0 sits in the most significant digit position of the code vector.
  function automatic logic [DIGIT_W-1:0] get_digit(input logic [CODE_W-1:0] vec,
                                                   input logic [IDX_W-1:0]  idx);
    int base;
    base = (CODE_LEN - 1 - int'(idx)) * DIGIT_W;
    return vec[base +: DIGIT_W];
  endfunction

  function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0]  vec,
                                                  input logic [IDX_W-1:0]   idx,
                                                  input logic [DIGIT_W-1:0] d);
    logic [CODE_W-1:0] r;
    int base;
    r    = vec;
    base = (CODE_LEN - 1 - int'(idx)) * DIGIT_W;
    r[base +: DIGIT_W] = d;
    return r;
  endfunction

  // {locked, unlocked, error_o, lockout}
  function automatic logic [3:0] flags_of(input state_t s);
    case (s)
      S_LOCKED:   return 4'b1000;
      S_UNLOCKED: return 4'b0100;
      S_ERROR:    return 4'b0010;
      S_LOCKOUT:  return 4'b0001;
      default:    return 4'b0000;
    endcase
  endfunction

  state_t             state;
  logic [3:0]         flags;
  logic               enter_q;
  logic [IDX_W-1:0]   idx;
  logic               mism;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [CODE_W-1:0]  code;
  logic [CODE_W-1:0]  shadow;
  logic               ev;
  logic               miss;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
  localparam int UNL_W = $clog2(UNLOCK_CYCLES + 1);
  localparam logic [UNL_W-1:0] UNL_LAST = UNL_W'(UNLOCK_CYCLES - 1);
  logic [UNL_W-1:0]   relock_cnt;
`endif

  assign ev   = bus.enter & ~enter_q;
  assign miss = (bus.digit != get_digit(code, idx));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LOCKED;
      flags    <= flags_of(S_LOCKED);
      enter_q  <= 1'b1;
      idx      <= '0;
      mism     <= 1'b0;
      fail_cnt <= '0;
      lock_cnt <= '0;
      code     <= CODE_INIT;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
      relock_cnt <= '0;
`endif
    end else begin
      enter_q <= bus.enter;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
      if (state != S_UNLOCKED) relock_cnt <= '0;
`endif
      case (state)
        S_LOCKED: begin
          if (bus.lock_cmd) begin
            idx  <= '0;
            mism <= 1'b0;
          end else if (ev) begin
            if (idx == LAST_IDX) begin
              idx  <= '0;
              mism <= 1'b0;
              if (!(mism || miss)) begin
                state    <= S_UNLOCKED;
                flags    <= flags_of(S_UNLOCKED);
                fail_cnt <= '0;
              end else begin
                fail_cnt <= fail_cnt + FAIL_W'(1);
                if (fail_cnt == FAIL_LAST) begin
                  state <= S_LOCKOUT;
                  flags <= flags_of(S_LOCKOUT);
                end else begin
                  state <= S_ERROR;
                  flags <= flags_of(S_ERROR);
                end
              end
            end else begin
              idx  <= idx + IDX_W'(1);
              mism <= mism | miss;
            end
          end
        end
        S_ERROR: begin
          if (bus.lock_cmd || ev) begin
            state <= S_LOCKED;
            flags <= flags_of(S_LOCKED);
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt == LOCK_LAST) begin
            lock_cnt <= '0;
            fail_cnt <= '0;
            state    <= S_LOCKED;
            flags    <= flags_of(S_LOCKED);
          end else begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
          end
        end
        S_UNLOCKED: begin
          if (bus.lock_cmd) begin
            state <= S_LOCKED;
            flags <= flags_of(S_LOCKED);
          end else if (bus.prog) begin
            idx   <= '0;
            state <= S_PROGRAM;
            flags <= flags_of(S_PROGRAM);
          end
`ifdef CODE_LOCK_AUTO_RELOCK_EN
          else if (relock_cnt == UNL_LAST) begin
            state <= S_LOCKED;
            flags <= flags_of(S_LOCKED);
          end else begin
            relock_cnt <= relock_cnt + UNL_W'(1);
          end
`endif
        end
        S_PROGRAM: begin
          if (bus.lock_cmd) begin
            idx   <= '0;
            state <= S_LOCKED;
            flags <= flags_of(S_LOCKED);
          end else if (ev) begin
            if (idx == LAST_IDX) begin
              // Last digit merged in the same edge so the stored code changes atomically.
              code  <= put_digit(shadow, idx, bus.digit);
              idx   <= '0;
              state <= S_LOCKED;
              flags <= flags_of(S_LOCKED);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          idx   <= '0;
          mism  <= 1'b0;
          state <= S_LOCKED;
          flags <= flags_of(S_LOCKED);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_PROGRAM && ev && !bus.lock_cmd)
      shadow <= put_digit(shadow, idx, bus.digit);
  end

  assign bus.locked     = flags[3];
  assign bus.unlocked   = flags[2];
  assign bus.error_o    = flags[1];
  assign bus.lockout    = flags[0];
  assign bus.state_code = state;
  assign bus.digit_idx  = idx;
endmodule

// File: tb/tb_code_lock_param.sv
// Directed bench for code_lock_param: entry, error, lockout, reprogramming,
// reset behaviour and the optional auto-relock (CODE_LOCK_AUTO_RELOCK_EN).
module tb_code_lock_param;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  code_lock_param_if #(.CODE_LEN(4), .DIGIT_W(4)) bus();

  code_lock_param #(
    .CODE_LEN(4), .DIGIT_W(4), .CODE_INIT(16'h1234), .MAX_TRIES(3),
    .LOCKOUT_CYCLES(20), .UNLOCK_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    bus.enter = 1'b1;
    bus.digit = d;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  task automatic press4(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
  endtask

  task automatic pulse_lock();
    @(negedge clk);
    bus.lock_cmd = 1'b1;
    @(negedge clk);
    bus.lock_cmd = 1'b0;
  endtask

  task automatic pulse_prog();
    @(negedge clk);
    bus.prog = 1'b1;
    @(negedge clk);
    bus.prog = 1'b0;
  endtask

  task automatic do_reset(input logic hold_enter);
    @(negedge clk);
    reset     = 1'b1;
    bus.enter = hold_enter;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    bus.enter = 1'b0; bus.digit = '0; bus.lock_cmd = 1'b0; bus.prog = 1'b0;
    reset = 1'b0;
    do_reset(1'b0);

    check("rst_locked",   32'(bus.locked),     32'd1);
    check("rst_unlocked", 32'(bus.unlocked),   32'd0);
    check("rst_error",    32'(bus.error_o),    32'd0);
    check("rst_lockout",  32'(bus.lockout),    32'd0);
    check("rst_state",    32'(bus.state_code), 32'd0);
    check("rst_idx",      32'(bus.digit_idx),  32'd0);

    // First digit held high for several cycles: a single event only.
    @(negedge clk);
    bus.enter = 1'b1; bus.digit = 4'h1;
    repeat (3) @(negedge clk);
    bus.enter = 1'b0;
    check("held_idx1", 32'(bus.digit_idx), 32'd1);
    press(4'h2); check("idx2", 32'(bus.digit_idx), 32'd2);
    press(4'h3); check("idx3", 32'(bus.digit_idx), 32'd3);
    press(4'h4);
    check("ok_unlocked", 32'(bus.unlocked),   32'd1);
    check("ok_state",    32'(bus.state_code), 32'd1);

    press(4'h1);
    check("unl_ignore_ev", 32'(bus.state_code), 32'd1);
    check("unl_ignore_idx", 32'(bus.digit_idx), 32'd0);

    pulse_lock();
    check("relock_cmd", 32'(bus.locked), 32'd1);

    // Wrong code #1 -> ERROR, one event returns to LOCKED
    press4(16'h1235);
    check("err1_flag",  32'(bus.error_o),    32'd1);
    check("err1_state", 32'(bus.state_code), 32'd2);
    press(4'h0);
    check("err1_back",  32'(bus.state_code), 32'd0);
    check("err1_idx",   32'(bus.digit_idx),  32'd0);

    // Wrong code #2 (mismatch early, all digits still taken)
    press4(16'h0234);
    check("err2_state", 32'(bus.state_code), 32'd2);
    press(4'h0);

    // Wrong code #3 -> LOCKOUT for 20 cycles, events ignored
    press4(16'h9999);
    check("lko_flag",  32'(bus.lockout),    32'd1);
    check("lko_state", 32'(bus.state_code), 32'd3);
    n = 0;
    bus.digit = 4'h1;
    while (bus.lockout && n < 100) begin
      n++;
      bus.enter = n[1];
      @(negedge clk);
    end
    bus.enter = 1'b0;
    check("lko_cycles", 32'(n), 32'd20);
    check("lko_exit",   32'(bus.locked), 32'd1);
    check("lko_idx",    32'(bus.digit_idx), 32'd0);
    press4(16'h1234);
    check("lko_unlock", 32'(bus.unlocked), 32'd1);

    // Reprogram to 9876
    pulse_prog();
    check("prog_state", 32'(bus.state_code), 32'd4);
    press(4'h9);
    check("prog_idx1", 32'(bus.digit_idx), 32'd1);
    press(4'h8); press(4'h7); press(4'h6);
    check("prog_done", 32'(bus.state_code), 32'd0);
    press4(16'h1234);
    check("old_code_err", 32'(bus.state_code), 32'd2);
    press(4'h0);
    press4(16'h9876);
    check("new_code_ok", 32'(bus.unlocked), 32'd1);

    // Reset mid-PROGRAM with enter held high across release
    pulse_prog();
    press(4'h5); press(4'h5);
    do_reset(1'b1);
    @(negedge clk);
    check("held_rst_idx",   32'(bus.digit_idx),  32'd0);
    check("held_rst_state", 32'(bus.state_code), 32'd0);
    bus.enter = 1'b0;
    press4(16'h1234);
    check("rst_restores_init", 32'(bus.unlocked), 32'd1);

    // Abort programming after two digits
    pulse_prog();
    press(4'h5); press(4'h5);
    pulse_lock();
    check("abort_state", 32'(bus.state_code), 32'd0);
    check("abort_idx",   32'(bus.digit_idx),  32'd0);
    press4(16'h1234);
    check("abort_keeps", 32'(bus.unlocked), 32'd1);

    // Auto-relock window measured from a fresh unlock
    pulse_lock();
    press4(16'h1234);
    n = 0;
    while (bus.unlocked && n < 100) begin
      n++;
      @(negedge clk);
    end
`ifdef CODE_LOCK_AUTO_RELOCK_EN
    check("relock_cycles", 32'(n), 32'd10);
    check("relock_locked", 32'(bus.locked), 32'd1);
`else
    check("no_relock_cycles", 32'(n), 32'd100);
    check("no_relock_unl",    32'(bus.unlocked), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
